// File: rtl/miner_pkg.sv
// Shared types, constants and byte-order helpers for the mining job controller.
package miner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_CHECK,
    ST_FOUND,
    ST_EXHAUST,
    ST_ABORT_WAIT,
    ST_ABORT
  } state_t;

  localparam logic [31:0] SHA_PAD_WORD = 32'h80000000;
  localparam logic [31:0] HDR_LEN_BITS = 32'd640;

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [255:0] bswap256(input logic [255:0] x);
    logic [255:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) begin
      y[8*i +: 8] = x[8*(31-i) +: 8];
    end
    return y;
  endfunction

endpackage

// File: rtl/miner_block1_fmt.sv
// Combinational builder for the second padded SHA-256 block of an 80-byte header.
module miner_block1_fmt
  import miner_pkg::*;
(
  input  logic [95:0]  i_hdr_tail,
  input  logic [31:0]  i_nonce,
  output logic [511:0] o_block1
);

  // Nonce sits little-endian in the header; length word covers the 640-bit message.
  assign o_block1 = {i_hdr_tail, bswap32(i_nonce), SHA_PAD_WORD, 320'd0, HDR_LEN_BITS};

endmodule

// File: rtl/miner_job_ctrl.sv
// Mining job controller: sweeps a nonce range through the double-SHA256 hasher.
// Optional MINER_HASH_COUNT_EN adds a saturating 64-bit hash_count output.
module miner_job_ctrl
  import miner_pkg::*;
#(
  parameter int NONCE_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [607:0]       job_header,
  input  logic [NONCE_W-1:0] job_nonce_first,
  input  logic [NONCE_W-1:0] job_nonce_last,
  input  logic [255:0]       job_target,
  input  logic               abort,
  output logic               sha_start,
  output logic [511:0]       sha_block0,
  output logic [511:0]       sha_block1,
  input  logic               sha_done,
  input  logic [255:0]       sha_hash2,
  output logic               busy,
  output logic               found_valid,
  output logic [NONCE_W-1:0] found_nonce,
  output logic [255:0]       found_hash,
  output logic               exhausted,
  output logic               aborted
`ifdef MINER_HASH_COUNT_EN
  , output logic [63:0]      hash_count
`endif
);

  state_t             r_state;
  logic               r_job_ready;
  logic               r_busy;
  logic               r_sha_start;
  logic               r_found_valid;
  logic               r_exhausted;
  logic               r_aborted;
  logic [NONCE_W-1:0] r_nonce;
  logic [NONCE_W-1:0] r_last;
  logic [255:0]       r_target;
  logic [255:0]       r_hash_rev;
  logic [511:0]       r_block0;
  logic [511:0]       r_block1;
  logic [NONCE_W-1:0] r_found_nonce;
  logic [255:0]       r_found_hash;

  logic [95:0]        w_fmt_tail;
  logic [NONCE_W-1:0] w_fmt_nonce;
  logic [511:0]       w_block1;
  logic               w_win;

  // In IDLE the formatter sees the incoming job; otherwise it prepares the next nonce.
  assign w_fmt_tail  = (r_state == ST_IDLE) ? job_header[95:0] : r_block1[511:416];
  assign w_fmt_nonce = (r_state == ST_IDLE) ? job_nonce_first : r_nonce + 1'b1;
  assign w_win       = (r_hash_rev <= r_target);

  miner_block1_fmt u_block1_fmt (
    .i_hdr_tail (w_fmt_tail),
    .i_nonce    (w_fmt_nonce),
    .o_block1   (w_block1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_job_ready   <= 1'b1;
      r_busy        <= 1'b0;
      r_sha_start   <= 1'b0;
      r_found_valid <= 1'b0;
      r_exhausted   <= 1'b0;
      r_aborted     <= 1'b0;
      r_nonce       <= '0;
      r_last        <= '0;
      r_target      <= '0;
      r_hash_rev    <= '0;
      r_block0      <= '0;
      r_block1      <= '0;
      r_found_nonce <= '0;
      r_found_hash  <= '0;
    end else begin
      r_sha_start   <= 1'b0;
      r_found_valid <= 1'b0;
      r_exhausted   <= 1'b0;
      r_aborted     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (job_valid && r_job_ready) begin
            r_nonce       <= job_nonce_first;
            r_last        <= job_nonce_last;
            r_target      <= job_target;
            r_block0      <= job_header[607:96];
            r_block1      <= w_block1;
            r_found_nonce <= '0;
            r_found_hash  <= '0;
            r_sha_start   <= 1'b1;
            r_busy        <= 1'b1;
            r_job_ready   <= 1'b0;
            r_state       <= ST_START;
          end
        end
        ST_START: r_state <= abort ? ST_ABORT_WAIT : ST_WAIT;
        ST_WAIT: begin
          if (sha_done) begin
            r_hash_rev <= bswap256(sha_hash2);
            if (abort) begin
              r_aborted <= 1'b1;
              r_state   <= ST_ABORT;
            end else begin
              r_state   <= ST_CHECK;
            end
          end else if (abort) begin
            r_state <= ST_ABORT_WAIT;
          end
        end
        ST_CHECK: begin
          if (abort) begin
            r_aborted <= 1'b1;
            r_state   <= ST_ABORT;
          end else if (w_win) begin
            r_found_valid <= 1'b1;
            r_found_nonce <= r_nonce;
            r_found_hash  <= r_hash_rev;
            r_state       <= ST_FOUND;
          end else if (r_nonce == r_last) begin
            r_exhausted <= 1'b1;
            r_state     <= ST_EXHAUST;
          end else begin
            r_nonce     <= r_nonce + 1'b1;
            r_block1    <= w_block1;
            r_sha_start <= 1'b1;
            r_state     <= ST_START;
          end
        end
        ST_ABORT_WAIT: begin
          if (sha_done) begin
            r_aborted <= 1'b1;
            r_state   <= ST_ABORT;
          end
        end
        default: begin
          r_busy      <= 1'b0;
          r_job_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MINER_HASH_COUNT_EN
  logic [63:0] r_hash_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hash_count <= '0;
    end else if (sha_done && (r_state == ST_WAIT || r_state == ST_ABORT_WAIT)
                 && (r_hash_count != '1)) begin
      r_hash_count <= r_hash_count + 64'd1;
    end
  end

  assign hash_count = r_hash_count;
`endif

  assign job_ready   = r_job_ready;
  assign busy        = r_busy;
  assign sha_start   = r_sha_start;
  assign sha_block0  = r_block0;
  assign sha_block1  = r_block1;
  assign found_valid = r_found_valid;
  assign found_nonce = r_found_nonce;
  assign found_hash  = r_found_hash;
  assign exhausted   = r_exhausted;
  assign aborted     = r_aborted;

endmodule

// File: tb/tb_miner_job_ctrl.sv
// Scoreboard bench for miner_job_ctrl with a behavioural fixed-latency hasher.
module tb_miner_job_ctrl;

  localparam int LAT = 12;
  localparam logic [607:0] GEN_HDR = {
    32'h01000000, 256'h0,
    256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
    32'h29ab5f49, 32'hffff001d};
  localparam logic [255:0] GEN_HASH =
    256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;
  localparam logic [255:0] GEN_TARGET = {32'h0, 32'hFFFF0000, 192'h0};
  localparam logic [607:0] ALT_HDR = {{16{32'hA5A50F0F}}, 96'hDEADBEEF_01234567_89ABCDEF};

  typedef enum {EV_START, EV_FOUND, EV_EXHAUST, EV_ABORT} ev_kind_t;
  typedef struct {
    ev_kind_t     kind;
    logic [31:0]  val;
    logic [255:0] hash;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         job_valid = 1'b0;
  logic         job_ready;
  logic [607:0] job_header = '0;
  logic [31:0]  job_nonce_first = '0;
  logic [31:0]  job_nonce_last = '0;
  logic [255:0] job_target = '0;
  logic         abort = 1'b0;
  logic         sha_start;
  logic [511:0] sha_block0;
  logic [511:0] sha_block1;
  logic         sha_done;
  logic [255:0] sha_hash2;
  logic         busy;
  logic         found_valid;
  logic [31:0]  found_nonce;
  logic [255:0] found_hash;
  logic         exhausted;
  logic         aborted;
`ifdef MINER_HASH_COUNT_EN
  logic [63:0]  hash_count;
`endif

  ev_t          exp_q[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           last_done_cyc = -100;
  logic [607:0] cur_hdr = '0;
  logic         spur_done = 1'b0;
  logic         m_done;
  logic [255:0] m_hash;
  logic [31:0]  m_nonce;
  int           m_cnt;

  miner_job_ctrl #(.NONCE_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .job_valid       (job_valid),
    .job_ready       (job_ready),
    .job_header      (job_header),
    .job_nonce_first (job_nonce_first),
    .job_nonce_last  (job_nonce_last),
    .job_target      (job_target),
    .abort           (abort),
    .sha_start       (sha_start),
    .sha_block0      (sha_block0),
    .sha_block1      (sha_block1),
    .sha_done        (sha_done),
    .sha_hash2       (sha_hash2),
    .busy            (busy),
    .found_valid     (found_valid),
    .found_nonce     (found_nonce),
    .found_hash      (found_hash),
    .exhausted       (exhausted),
    .aborted         (aborted)
`ifdef MINER_HASH_COUNT_EN
    , .hash_count    (hash_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] rev256(input logic [255:0] x);
    logic [255:0] y;
    for (int i = 0; i < 32; i++) y[8*i +: 8] = x[255-8*i -: 8];
    return y;
  endfunction

  // Model digest in display order: the genesis nonce gets the real genesis hash,
  // every other nonce a large value that loses against any target used here.
  function automatic logic [255:0] model_rev(input logic [31:0] n);
    if (n == 32'h7C2BAC1D) return GEN_HASH;
    return {~n, {7{32'hFEEDFACE}}};
  endfunction

  // Behavioural hasher: fixed latency, shares the reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt   <= 0;
      m_done  <= 1'b0;
      m_hash  <= '0;
      m_nonce <= '0;
    end else begin
      m_done <= 1'b0;
      if (sha_start) begin
        m_cnt   <= LAT;
        m_nonce <= {sha_block1[391:384], sha_block1[399:392], sha_block1[407:400], sha_block1[415:408]};
      end else if (m_cnt == 1) begin
        m_cnt  <= 0;
        m_done <= 1'b1;
        m_hash <= rev256(model_rev(m_nonce));
      end else if (m_cnt > 1) begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  assign sha_done  = m_done | spur_done;
  assign sha_hash2 = m_hash;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic push_ev(input ev_kind_t k, input logic [31:0] v, input logic [255:0] h);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.hash = h;
    exp_q.push_back(e);
  endtask

  task automatic take(input ev_kind_t k, input string nm);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk({"unexpected_", nm}, 512'd1, 512'd0);
      return;
    end
    e = exp_q.pop_front();
    chk({"event_kind_", nm}, 512'(k), 512'(e.kind));
    if (k != e.kind) return;
    case (k)
      EV_START: begin
        chk("start_block1", sha_block1,
            {cur_hdr[95:0], e.val, 32'h80000000, 320'h0, 32'h00000280});
        chk("start_block0", sha_block0, cur_hdr[607:96]);
      end
      EV_FOUND: begin
        chk("found_nonce", 512'(found_nonce), 512'(e.val));
        chk("found_hash", 512'(found_hash), 512'(e.hash));
      end
      EV_ABORT: chk("abort_latency", 512'(cyc), 512'(last_done_cyc + 1));
      default: ;
    endcase
  endtask

  // Monitor: pops one expectation per observed strobe.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (sha_done) last_done_cyc = cyc;
        if (sha_start)   take(EV_START, "start");
        if (found_valid) take(EV_FOUND, "found");
        if (exhausted)   take(EV_EXHAUST, "exhausted");
        if (aborted)     take(EV_ABORT, "aborted");
      end
    end
  end

  task automatic go(input logic [31:0] first, input logic [31:0] last, input logic [255:0] tgt);
    @(posedge clk); #1;
    job_header      = cur_hdr;
    job_nonce_first = first;
    job_nonce_last  = last;
    job_target      = tgt;
    job_valid       = 1'b1;
    @(posedge clk); #1;
    job_valid = 1'b0;
    chk("accept_busy", 512'(busy), 512'd1);
  endtask

  task automatic wait_q(input int target_size, input string nm);
    int i;
    for (i = 0; i < 600 && exp_q.size() > target_size; i++) @(negedge clk);
    chk({nm, "_no_timeout"}, 512'(i < 600), 512'd1);
  endtask

  task automatic wait_drain(input string nm);
    int i;
    wait_q(0, nm);
    for (i = 0; i < 20 && job_ready !== 1'b1; i++) @(negedge clk);
    chk({nm, "_job_ready"}, 512'(job_ready), 512'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_job_ready", 512'(job_ready), 512'd1);
    chk("rst_busy", 512'(busy), 512'd0);
    chk("rst_block1", sha_block1, 512'd0);
    rst = 1'b0;

    // Genesis sweep: fourth nonce wins.
    cur_hdr = GEN_HDR;
    push_ev(EV_START, 32'h1AAC2B7C, '0);
    push_ev(EV_START, 32'h1BAC2B7C, '0);
    push_ev(EV_START, 32'h1CAC2B7C, '0);
    push_ev(EV_START, 32'h1DAC2B7C, '0);
    push_ev(EV_FOUND, 32'h7C2BAC1D, GEN_HASH);
    go(32'h7C2BAC1A, 32'h7C2BAC20, GEN_TARGET);
    chk("busy_job_ready", 512'(job_ready), 512'd0);
    wait_drain("genesis");

    // Range 0..3 against an impossible target.
    push_ev(EV_START, 32'h00000000, '0);
    push_ev(EV_START, 32'h01000000, '0);
    push_ev(EV_START, 32'h02000000, '0);
    push_ev(EV_START, 32'h03000000, '0);
    push_ev(EV_EXHAUST, '0, '0);
    go(32'd0, 32'd3, 256'd0);
    wait_drain("exhaust");

    // Wrap through 0xFFFFFFFF.
    cur_hdr = ALT_HDR;
    push_ev(EV_START, 32'hFEFFFFFF, '0);
    push_ev(EV_START, 32'hFFFFFFFF, '0);
    push_ev(EV_START, 32'h00000000, '0);
    push_ev(EV_START, 32'h01000000, '0);
    push_ev(EV_EXHAUST, '0, '0);
    go(32'hFFFFFFFE, 32'h00000001, 256'd0);
    wait_drain("wrap");

    // Abort five cycles into WAIT: in-flight hash drains, no new start.
    push_ev(EV_START, 32'h00000000, '0);
    push_ev(EV_ABORT, '0, '0);
    go(32'd0, 32'd10, 256'd0);
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wait_drain("abort");

    // Asynchronous reset in WAIT.
    push_ev(EV_START, 32'h00000000, '0);
    go(32'd0, 32'd5, 256'd0);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_busy", 512'(busy), 512'd0);
    chk("midrst_job_ready", 512'(job_ready), 512'd1);
    chk("midrst_block0", sha_block0, 512'd0);
    chk("midrst_block1", sha_block1, 512'd0);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;

    // Single-nonce job with job_valid held high: one hash per accepted job.
    cur_hdr = GEN_HDR;
    push_ev(EV_START, 32'h1DAC2B7C, '0);
    push_ev(EV_FOUND, 32'h7C2BAC1D, GEN_HASH);
    push_ev(EV_START, 32'h1DAC2B7C, '0);
    push_ev(EV_FOUND, 32'h7C2BAC1D, GEN_HASH);
    @(posedge clk); #1;
    job_header      = cur_hdr;
    job_nonce_first = 32'h7C2BAC1D;
    job_nonce_last  = 32'h7C2BAC1D;
    job_target      = GEN_TARGET;
    job_valid       = 1'b1;
    wait_q(2, "held_first");
`ifdef MINER_HASH_COUNT_EN
    chk("hash_count_one", 512'(hash_count), 512'd1);
`endif
    wait_q(0, "held_second");
    job_valid = 1'b0;
    wait_drain("held");
`ifdef MINER_HASH_COUNT_EN
    chk("hash_count_two", 512'(hash_count), 512'd2);
`endif

    // Stray sha_done and abort while IDLE must do nothing.
    @(posedge clk); #1 spur_done = 1'b1; abort = 1'b1;
    @(posedge clk); #1 spur_done = 1'b0; abort = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_stray_busy", 512'(busy), 512'd0);
    chk("final_queue_empty", 512'(exp_q.size()), 512'd0);
`ifdef MINER_HASH_COUNT_EN
    chk("hash_count_stray", 512'(hash_count), 512'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/miner_job_ctrl.md
Name: miner_job_ctrl

Overview:
Initiator side of the double-SHA256 hasher handshake. It accepts a mining job: a 76-byte header prefix, a nonce range and a target. It builds the two padded 512-bit blocks for each nonce, pulses the hasher's start and waits for its done. It compares each result against the target and reports the first winning nonce, or reports that the range is exhausted. It sits between the job/host interface and the sha256_double instance.

Parameters:
NONCE_W, 32, nonce width; fixed by the Bitcoin header format; exposed only for bench readability.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
job_valid  in  1  job offered
job_ready  out  1  high in IDLE only
job_header  in  608  header bytes 0..75, byte 0 in bits [607:600]
job_nonce_first  in  32  first nonce, inclusive
job_nonce_last  in  32  last nonce, inclusive
job_target  in  256  numeric target; hash wins when hash <= target
abort  in  1  cancel current job
sha_start  out  1  1-cycle start pulse to the hasher
sha_block0  out  512  header bytes 0..63
sha_block1  out  512  bytes 64..79 plus padding
sha_done  in  1  hasher result strobe
sha_hash2  in  256  hasher digest, standard big-endian word order
busy  out  1  job in progress
found_valid  out  1  1-cycle pulse: nonce found
found_nonce  out  32  winning nonce, held until the next job
found_hash  out  256  byte-reversed digest, numeric/display order
exhausted  out  1  1-cycle pulse: range done, nothing found
aborted  out  1  1-cycle pulse: job cancelled

Behaviour:
- Reset values: state IDLE; job_ready=1; all other outputs 0; internal registers 0.
- Handshake: a job is accepted on a cycle where job_valid && job_ready are both high. All job fields are latched. Inputs are ignored while busy.
- States:
  - IDLE -> START on accept.
  - START: sha_start=1 for exactly one cycle -> WAIT.
  - WAIT: stay until sha_done -> CHECK. Latch sha_hash2 on sha_done.
  - CHECK:
    - Win -> FOUND.
    - Else, nonce==last -> EXHAUST.
    - Else, nonce+1 -> START.
  - FOUND, EXHAUST and ABORT each pulse their own strobe for one cycle -> IDLE.
- Block building:
  - sha_block0 = job_header[607:96].
  - sha_block1 words W0..W15:
    - W0..W2 = job_header[95:0].
    - W3 = byte-swapped current nonce (the nonce is little-endian in the header).
    - W4 = 32'h80000000.
    - W5..W14 = 0.
    - W15 = 32'h00000280 (640 bits).
  - Both blocks are driven from registers and stay stable from START through sha_done.
- Compare:
  - rev = byte-reversal of sha_hash2 (byte 31 becomes the MSB).
  - Win when rev <= job_target, as an unsigned 256-bit compare.
  - found_hash = rev.
- Latency: one hash costs hasher latency + 3 cycles (START, CHECK, plus the cycle where WAIT sees sha_done). found_valid is asserted on the cycle after CHECK.
- Boundaries:
  - first==last: exactly one hash is run.
  - first>last: nonce counts up through 0xFFFFFFFF and wraps to 0 until it equals last. No special case.
  - Full 2^32 range (first=0, last=0xFFFFFFFF): no overflow; the equality test ends the job.
  - sha_done outside WAIT: ignored.
- abort:
  - In IDLE: no effect.
  - In START or WAIT: go to an ABORT_WAIT state. Drain the in-flight hash (wait for sha_done), then ABORT.
  - In CHECK: takes priority over found/exhaust. No found pulse.
  - The hasher cannot be cancelled, so the in-flight hash is always drained.
- Reset mid-job: immediate return to IDLE with reset values. The hasher shares rst.

Optional Feature:
MINER_HASH_COUNT_EN
- Defined: adds output hash_count [63:0].
  - Increments on every sha_done accepted in WAIT or ABORT_WAIT.
  - Clears only on rst; it is not cleared by a new job.
  - Saturates at all-ones.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package miner_pkg:
  - state enum.
  - SHA_PAD_WORD = 32'h80000000.
  - HDR_LEN_BITS = 32'd640.
  - bswap32 function.
  - bswap256 function.
- Sub-module miner_block1_fmt: combinational nonce/header-tail -> block1 formatter. It is reused by the future midstate path.
- Controller FSM and comparator stay in miner_job_ctrl.

Test Plan:
- Genesis header, first=0x7C2BAC1A, last=0x7C2BAC20, target=0x00000000FFFF0000...0, real sha256_double -> found_valid after 4 hashes; found_nonce=0x7C2BAC1D; found_hash=000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f.
- Same header, range 0..3, target=0 -> 4 sha_start pulses, exhausted pulse, no found_valid, job_ready back to 1.
- Behavioural hasher model, first=0xFFFFFFFE, last=0x00000001 -> nonces FFFFFFFE, FFFFFFFF, 0, 1 appear byte-swapped in W3; exhausted pulse.
- abort asserted 5 cycles into WAIT -> no new sha_start; aborted pulses 1 cycle after the delayed sha_done; job_ready=1.
- rst asserted while in WAIT -> all outputs 0 asynchronously; a new job is accepted cleanly after release.
- first==last==0x7C2BAC1D with a winning target, and job_valid held high throughout -> exactly one hash; second job not accepted until IDLE; with the macro defined, hash_count=1.
